// File: rtl/wb_burst_pkg.sv
// Shared types and constants for the Wishbone burst master and its buffers.
package wb_burst_pkg;
   localparam int         CTI_W       = 3;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   typedef enum logic [1:0] {IDLE, WAIT_RES, BURST, DONE} state_t;

   // Counter width able to hold the value `depth` itself.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/wb_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a multi-word drop.
module wb_sync_fifo
   import wb_burst_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = cnt_w(DEPTH)
) (
   input  logic             wb_clk,
   input  logic             wb_rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic [CW-1:0]    pop_n,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] dout_nxt,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    pop_amt;
   logic             push_ok;

   // pop_n > 1 discards several words at once; a push into a full buffer is
   // only accepted when the same cycle frees a slot.
   always_comb begin
      pop_amt = (pop_n > count) ? count : pop_n;
      push_ok = push && ((count != CW'(DEPTH)) || (pop_amt != '0));
   end

   assign dout     = mem[rd_ptr];
   assign dout_nxt = mem[rd_ptr + AW'(1)];

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr + pop_amt[AW-1:0];
         count  <= count + CW'(push_ok) - pop_amt;
      end
   end

   always_ff @(posedge wb_clk)
      if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/wb_burst_master.sv
// Command/data stream to Wishbone B3 single and incrementing-burst cycles.
module wb_burst_master
   import wb_burst_pkg::*;
#(
   parameter  int APP_AW     = 26,
   parameter  int dw         = 32,
   parameter  int MAX_BURST  = 8,
   parameter  int FIFO_DEPTH = 16,
   parameter  int TIMEOUT    = 255,
   localparam int LW         = $clog2(MAX_BURST) + 1
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [APP_AW-1:0] cmd_addr,
   input  logic [LW-1:0]     cmd_len,
   input  logic [dw/8-1:0]   cmd_sel,
   input  logic              wdat_valid,
   output logic              wdat_ready,
   input  logic [dw-1:0]     wdat_data,
   output logic              rdat_valid,
   input  logic              rdat_ready,
   output logic [dw-1:0]     rdat_data,
   output logic              rdat_last,
   output logic              done_valid,
   output logic              done_err,
   output logic              wb_cyc,
   output logic              wb_stb,
   output logic              wb_we,
   output logic [APP_AW-1:0] wb_addr,
   output logic [dw/8-1:0]   wb_sel,
   output logic [dw-1:0]     wb_dati,
   output logic [CTI_W-1:0]  wb_cti,
   input  logic [dw-1:0]     wb_dato,
   input  logic              wb_ack
);
   localparam int CW = cnt_w(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          state, state_nxt;
   logic            we_q;
   logic [LW-1:0]   len_q, rem, len_c;
   logic [TW-1:0]   wdog;
   logic            cmd_hs, ack_ok, last_beat, tmo, res_ok, rf_push;
   logic [CW-1:0]   wf_count, rf_count, wf_pop_n, rf_pop_n;
   logic [dw-1:0]   wf_head, wf_next;
   logic [dw:0]     rf_dout, unused_rf_nxt;

   assign cmd_ready  = (state == IDLE) && !wb_rst;
   assign cmd_hs     = cmd_valid && cmd_ready;
   assign ack_ok     = wb_ack && wb_stb;
   assign last_beat  = (rem == LW'(1));
   assign tmo        = wb_stb && !wb_ack && (wdog == TW'(TIMEOUT - 1));
   assign res_ok     = we_q ? (wf_count >= CW'(len_q))
                            : ((CW'(FIFO_DEPTH) - rf_count) >= CW'(len_q));
   assign wdat_ready = (wf_count != CW'(FIFO_DEPTH));
   assign rdat_valid = (rf_count != '0);
   assign rf_pop_n   = CW'(rdat_valid && rdat_ready);
   assign {rdat_last, rdat_data} = rf_dout;

   always_comb begin
      len_c = cmd_len;
      if (cmd_len == '0)                   len_c = LW'(1);
      else if (cmd_len > LW'(MAX_BURST))   len_c = LW'(MAX_BURST);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (cmd_hs) state_nxt = WAIT_RES;
         WAIT_RES: if (res_ok) state_nxt = BURST;
         BURST:    if ((ack_ok && last_beat) || tmo) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // On a write abort every unsent word of the command is dropped at once.
   always_comb begin
      wf_pop_n = '0;
      rf_push  = 1'b0;
      if (state == BURST) begin
         if (ack_ok && we_q)   wf_pop_n = CW'(1);
         else if (tmo && we_q) wf_pop_n = CW'(rem);
         rf_push = ack_ok && !we_q;
      end
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         len_q      <= '0;
         rem        <= '0;
         wdog       <= '0;
         wb_cyc     <= 1'b0;
         wb_stb     <= 1'b0;
         wb_we      <= 1'b0;
         wb_addr    <= '0;
         wb_sel     <= '0;
         wb_dati    <= '0;
         wb_cti     <= CTI_CLASSIC;
         done_valid <= 1'b0;
         done_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         done_valid <= 1'b0;
         done_err   <= 1'b0;
         case (state)
            IDLE: if (cmd_hs) begin
               we_q    <= cmd_we;
               len_q   <= len_c;
               rem     <= len_c;
               wb_addr <= cmd_addr;
               wb_sel  <= cmd_sel;
            end
            WAIT_RES: if (res_ok) begin
               wb_cyc  <= 1'b1;
               wb_stb  <= 1'b1;
               wb_we   <= we_q;
               wb_dati <= wf_head;
               wb_cti  <= (len_q == LW'(1)) ? CTI_CLASSIC : CTI_INCR;
               wdog    <= '0;
            end
            BURST: begin
               if (ack_ok) begin
                  wdog    <= '0;
                  wb_addr <= wb_addr + APP_AW'(dw / 8);
                  rem     <= rem - LW'(1);
                  wb_dati <= wf_next;
                  if (rem == LW'(2)) wb_cti <= CTI_END;
                  if (last_beat) begin
                     wb_cyc     <= 1'b0;
                     wb_stb     <= 1'b0;
                     wb_we      <= 1'b0;
                     wb_cti     <= CTI_CLASSIC;
                     done_valid <= 1'b1;
                  end
               end else if (tmo) begin
                  wdog       <= '0;
                  wb_cyc     <= 1'b0;
                  wb_stb     <= 1'b0;
                  wb_we      <= 1'b0;
                  wb_cti     <= CTI_CLASSIC;
                  done_valid <= 1'b1;
                  done_err   <= 1'b1;
               end else if (wb_stb) begin
                  wdog <= wdog + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   wb_sync_fifo #(.WIDTH(dw), .DEPTH(FIFO_DEPTH)) u_wbuf (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .flush(1'b0),
      .push(wdat_valid && wdat_ready), .din(wdat_data), .pop_n(wf_pop_n),
      .dout(wf_head), .dout_nxt(wf_next), .count(wf_count)
   );

   wb_sync_fifo #(.WIDTH(dw + 1), .DEPTH(FIFO_DEPTH)) u_rbuf (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .flush(1'b0),
      .push(rf_push), .din({last_beat, wb_dato}), .pop_n(rf_pop_n),
      .dout(rf_dout), .dout_nxt(unused_rf_nxt), .count(rf_count)
   );
endmodule

// File: tb/tb_wb_burst_master.sv
// Randomised scoreboard bench for wb_burst_master against a transaction-level model.
module tb_wb_burst_master;
   logic        wb_clk, wb_rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [25:0] cmd_addr;
   logic [3:0]  cmd_len, cmd_sel;
   logic        wdat_valid, wdat_ready;
   logic [31:0] wdat_data;
   logic        rdat_valid, rdat_ready, rdat_last;
   logic [31:0] rdat_data;
   logic        done_valid, done_err;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [25:0] wb_addr;
   logic [3:0]  wb_sel;
   logic [31:0] wb_dati, wb_dato;
   logic [2:0]  wb_cti;

   typedef struct {
      logic        we;
      logic [25:0] addr;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic [31:0] dat;
      bit          last;
   } beat_t;

   beat_t       beat_q[$];
   logic [32:0] rd_q[$];
   bit          done_q[$];
   logic [31:0] wq[$];

   int checks = 0, errors = 0, cyc_cnt = 0;
   bit sb_on = 1, rd_en = 1, rd_rand = 0;
   int slv_mode = 0;

   wb_burst_master dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
      .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
      .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data),
      .rdat_last(rdat_last), .done_valid(done_valid), .done_err(done_err),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_sel(wb_sel), .wb_dati(wb_dati), .wb_cti(wb_cti),
      .wb_dato(wb_dato), .wb_ack(wb_ack)
   );

   initial begin
      wb_clk = 0;
      forever #5 wb_clk = ~wb_clk;
   end

   function automatic logic [31:0] slave_fn(input logic [25:0] a);
      if (a == 26'h3FFFFFC) return 32'hDEADBEEF;
      return (32'(a) * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   assign wb_dato = slave_fn(wb_addr);

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s (bound expired)", nm);
   endtask

   // Slave: mode 0 zero-wait, 1 random 0..2 wait states, 2 never acks.
   initial begin
      int wcnt = 0;
      wb_ack = 0;
      forever begin
         @(negedge wb_clk);
         if (!wb_stb || slv_mode == 2) wb_ack = 0;
         else if (wcnt == 0) begin
            wb_ack = 1;
            wcnt = (slv_mode == 1) ? int'($urandom_range(0, 2)) : 0;
         end else begin
            wb_ack = 0;
            wcnt--;
         end
      end
   end

   initial begin
      rdat_ready = 0;
      forever begin
         @(negedge wb_clk);
         rdat_ready = rd_rand ? ($urandom_range(0, 3) != 0) : rd_en;
      end
   end

   // Monitors sample 2 time units after the falling edge.
   initial begin
      int    dstage = 0;
      beat_t e;
      forever begin
         @(negedge wb_clk); #2;
         if (wb_cyc) cyc_cnt++;
         if (sb_on) begin
            if (dstage == 1) begin
               check("done_after_last_ack", {done_valid, wb_cyc}, 2'b10);
               dstage = 2;
            end else if (dstage == 2) begin
               check("ready_after_done", cmd_ready, 1'b1);
               dstage = 0;
            end
            if (wb_cyc && wb_stb && wb_ack) begin
               if (beat_q.size() == 0) fail("unexpected_beat");
               else begin
                  e = beat_q.pop_front();
                  check("wb_beat", {wb_we, wb_addr, wb_sel, wb_cti, wb_we ? wb_dati : 32'h0},
                                   {e.we, e.addr, e.sel, e.cti, e.we ? e.dat : 32'h0});
                  if (e.last) dstage = 1;
               end
            end
            if (done_valid) begin
               if (done_q.size() == 0) fail("unexpected_done");
               else check("done_err", done_err, done_q.pop_front());
            end
            if (rdat_valid && rdat_ready) begin
               if (rd_q.size() == 0) fail("unexpected_rdat");
               else check("rdat", {rdat_last, rdat_data}, rd_q.pop_front());
            end
         end
      end
   end

   task automatic push_w(input logic [31:0] d);
      int n = 0;
      @(negedge wb_clk);
      wdat_valid = 1;
      wdat_data  = d;
      #1;
      while (!wdat_ready && n < 500) begin @(negedge wb_clk); #1; n++; end
      if (!wdat_ready) fail("wdat_ready_wait");
      @(posedge wb_clk); #1;
      wdat_valid = 0;
      wq.push_back(d);
   endtask

   task automatic issue(input logic we, input logic [25:0] a, input logic [3:0] len,
                        input logic [3:0] sel, input bit tmo);
      int          n = 0, len_e;
      beat_t       b;
      logic [31:0] tmp;
      @(negedge wb_clk);
      cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_len = len; cmd_sel = sel;
      #1;
      while (!cmd_ready && n < 2000) begin @(negedge wb_clk); #1; n++; end
      if (!cmd_ready) fail("cmd_ready_wait");
      @(posedge wb_clk); #1;
      cmd_valid = 0;
      len_e = (len == 0) ? 1 : (len > 8) ? 8 : int'(len);
      for (int i = 0; i < len_e; i++) begin
         b.we   = we;
         b.addr = a + 26'(4 * i);
         b.sel  = sel;
         b.cti  = (len_e == 1) ? 3'b000 : (i == len_e - 1) ? 3'b111 : 3'b010;
         b.last = (i == len_e - 1);
         b.dat  = 32'h0;
         if (!tmo) begin
            if (we) b.dat = wq.pop_front();
            beat_q.push_back(b);
            if (!we) rd_q.push_back({b.last, slave_fn(b.addr)});
         end
      end
      if (tmo && we) repeat (len_e) tmp = wq.pop_front();
      done_q.push_back(tmo);
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_q.size() != 0 && n < 3000) begin @(negedge wb_clk); n++; end
      if (done_q.size() != 0) fail("done_wait");
      repeat (2) @(negedge wb_clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit");
      $fatal(1, "time limit");
   end

   initial begin
      int c0, n, nb, dv;
      logic [3:0] len;
      logic       we;
      wb_rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_len = 0; cmd_sel = 0;
      wdat_valid = 0; wdat_data = 0;
      #2;
      check("rst_wb_ctl", {wb_cyc, wb_stb, wb_we}, 3'b000);
      check("rst_wb_addr", wb_addr, 26'h0);
      check("rst_wb_sel_cti", {wb_sel, wb_cti}, 7'h0);
      check("rst_wb_dati", wb_dati, 32'h0);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_status", {rdat_valid, done_valid, done_err}, 3'b000);
      repeat (3) @(negedge wb_clk);
      wb_rst = 0;
      #2;
      check("cmd_ready_after_rst", cmd_ready, 1'b1);

      // Zero-wait write burst of 4.
      for (int i = 0; i < 4; i++) push_w(32'hA0 + 32'(i));
      c0 = cyc_cnt;
      issue(1, 26'h100, 4, 4'hF, 0);
      wait_done();
      check("burst_no_gaps", cyc_cnt - c0, 4);

      // Single read at the top of the address space, with start latency.
      issue(0, 26'h3FFFFFC, 1, 4'hF, 0);
      @(negedge wb_clk); #2;
      check("lat_wait_res", wb_cyc, 1'b0);
      @(negedge wb_clk); #2;
      check("lat_stb", wb_cyc, 1'b1);
      wait_done();

      // Read buffer holding 12 words blocks an 8-beat read until space frees.
      rd_en = 0;
      issue(0, 26'h2000, 8, 4'h3, 0); wait_done();
      issue(0, 26'h3000, 4, 4'hC, 0); wait_done();
      issue(0, 26'h4000, 8, 4'hF, 0);
      c0 = cyc_cnt;
      repeat (20) @(negedge wb_clk);
      check("wait_res_hold", cyc_cnt - c0, 0);
      rd_en = 1;
      wait_done();
      n = 0;
      while (rd_q.size() != 0 && n < 200) begin @(negedge wb_clk); n++; end
      if (rd_q.size() != 0) fail("rd_drain");

      // Watchdog abort on a write that is never acknowledged.
      push_w(32'h1111_1111); push_w(32'h2222_2222);
      slv_mode = 2;
      c0 = cyc_cnt;
      issue(1, 26'h500, 2, 4'hF, 1);
      wait_done();
      check("timeout_cycles", cyc_cnt - c0, 255);
      slv_mode = 0;
      push_w(32'h3333_3333); push_w(32'h4444_4444);
      issue(1, 26'h600, 2, 4'h5, 0);
      wait_done();

      // Address wrap.
      for (int i = 0; i < 4; i++) push_w($urandom);
      issue(1, 26'h3FFFFF8, 4, 4'hF, 0);
      wait_done();

      // Random traffic, random wait states and read backpressure.
      slv_mode = 1; rd_rand = 1;
      for (int k = 0; k < 40; k++) begin
         we  = 1'($urandom_range(0, 1));
         len = 4'($urandom_range(0, 15));
         if (we) repeat ((len == 0) ? 1 : (len > 8) ? 8 : int'(len)) push_w($urandom);
         issue(we, 26'($urandom), len, 4'($urandom), 0);
         wait_done();
      end
      n = 0;
      while (rd_q.size() != 0 && n < 500) begin @(negedge wb_clk); n++; end
      if (rd_q.size() != 0) fail("rd_drain_rand");
      slv_mode = 0; rd_rand = 0; rd_en = 1;

      // Asynchronous reset on the second beat of an 8-beat read.
      sb_on = 0;
      issue(0, 26'h7000, 8, 4'hF, 0);
      nb = 0; n = 0;
      while (nb < 2 && n < 100) begin
         @(negedge wb_clk); #2;
         if (wb_cyc && wb_stb && wb_ack) begin
            nb++;
            if (nb == 2) begin
               wb_rst = 1;
               #1;
               check("rst_mid_burst_cyc", wb_cyc, 1'b0);
            end
         end
         n++;
      end
      if (nb < 2) fail("rst_mid_burst_beats");
      dv = 0;
      repeat (2) begin @(negedge wb_clk); #2; if (done_valid) dv++; end
      wb_rst = 0;
      repeat (10) begin @(negedge wb_clk); #2; if (done_valid) dv++; end
      check("rst_no_done", dv, 0);
      check("rst_rdat_empty", rdat_valid, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      beat_q.delete(); rd_q.delete(); done_q.delete(); wq.delete();
      sb_on = 1;
      for (int i = 0; i < 3; i++) push_w($urandom);
      issue(1, 26'h8000, 3, 4'h9, 0);
      wait_done();
      check("sb_empty", {32'(beat_q.size()), 32'(rd_q.size())}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
